uart_rx_fifo: RTL and testbench

- Standalone UART receiver with a show-ahead receive FIFO.
- Sits at the far end of a UART serial line. It deserialises asynchronous 8-bit frames (start, 8 data LSB-first, optional parity, stop), checks them, buffers bytes for a host, and reports errors in a status byte.
- Bit period is programmed in system clocks; the line is sampled at mid-bit.

---
 rtl/uart_rx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: mid-bit sampling UART receiver with a show-ahead receive FIFO and sticky error status
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] baudrate,
  input  logic [7:0]  control,
  input  logic        rxd,
  input  logic        read_rx,
  output logic        rx_valid,
  output logic [7:0]  rxdata,
  output logic [7:0]  status
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic s1, rxs, rxs_d;
  logic [15:0] cnt, baud_r, baud_eff, half_m1;
  logic [2:0] idx;
  logic [7:0] data;
  logic par_en, odd_r, perr;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, rptr_nx, wptr_nx;
  logic en, tick, fall, samp_stop, push, pop, full, wr;
  logic ovr_ev, fe_ev, pe_ev, brk_ev;
  logic st_ovr, st_fe, st_pe, st_brk;
  logic unused_ctrl;
  assign unused_ctrl = ^{control[7:6], control[3]};
  assign en        = control[0];
  assign baud_eff  = (baudrate < 16'd4) ? 16'd4 : baudrate;
  assign half_m1   = (baud_eff >> 1) - 16'd1;
  assign tick      = cnt == 16'd0;
  assign fall      = rxs_d && !rxs;
  assign samp_stop = en && state == STOP && tick;
  assign push      = samp_stop && rxs;
  assign fe_ev     = samp_stop && !rxs;
  assign brk_ev    = fe_ev && data == 8'h00 && !perr;
  assign pe_ev     = en && state == PARITY && tick && ((^data ^ rxs) != odd_r);
  assign rx_valid  = wptr != rptr;
  assign full      = wptr == {~rptr[AW], rptr[AW-1:0]};
  assign pop       = read_rx && rx_valid;
  assign wr        = push && !control[4] && (!full || pop);
  assign ovr_ev    = push && !control[4] && full && !pop;
  assign rptr_nx   = rptr + {{AW{1'b0}}, pop};
  assign wptr_nx   = wptr + {{AW{1'b0}}, wr};
  assign status    = {1'b0, st_brk, state != IDLE, st_pe, st_fe, st_ovr, full, rx_valid};
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      s1    <= rxd;
      rxs   <= s1;
      rxs_d <= rxs;
    end
  end
  // Frame configuration is latched on the start edge so mid-frame control changes cannot corrupt it
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      baud_r <= 16'd4;
      idx    <= '0;
      data   <= '0;
      par_en <= 1'b0;
      odd_r  <= 1'b0;
      perr   <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (fall) begin
          state  <= START;
          cnt    <= half_m1;
          baud_r <= baud_eff;
          par_en <= control[1];
          odd_r  <= control[2];
        end
        START: if (tick) begin
          state <= rxs ? IDLE : DATA;
          cnt   <= baud_r - 16'd1;
          idx   <= '0;
          perr  <= 1'b0;
        end else cnt <= cnt - 16'd1;
        DATA: if (tick) begin
          data  <= {rxs, data[7:1]};
          idx   <= idx + 3'd1;
          cnt   <= baud_r - 16'd1;
          state <= (idx == 3'd7) ? (par_en ? PARITY : STOP) : DATA;
        end else cnt <= cnt - 16'd1;
        PARITY: if (tick) begin
          perr  <= pe_ev;
          state <= STOP;
          cnt   <= baud_r - 16'd1;
        end else cnt <= cnt - 16'd1;
        STOP: if (tick) state <= IDLE;
              else cnt <= cnt - 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) if (wr) mem[wptr[AW-1:0]] <= data;
  // rxdata is registered from the post-update head, so a push into an empty FIFO shows next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      rxdata <= '0;
    end else if (control[4]) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr_nx;
      rptr <= rptr_nx;
      if (wptr_nx != rptr_nx) rxdata <= (wr && wptr == rptr_nx) ? data : mem[rptr_nx[AW-1:0]];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_ovr <= 1'b0;
      st_fe  <= 1'b0;
      st_pe  <= 1'b0;
      st_brk <= 1'b0;
    end else begin
      st_ovr <= (st_ovr && !control[5]) || ovr_ev;
      st_fe  <= (st_fe  && !control[5]) || fe_ev;
      st_pe  <= (st_pe  && !control[5]) || pe_ev;
      st_brk <= (st_brk && !control[5]) || brk_ev;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven frames plus timed sequences, received bytes checked against a scoreboard queue
module tb_uart_rx_fifo;
  logic clk = 0, reset = 1, rxd = 1, read_rx = 0;
  logic [15:0] baudrate = 16'd16;
  logic [7:0] control = 8'h00;
  logic rx_valid;
  logic [7:0] rxdata, status;
  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] data;
    bit         bad;
    bit         stop;
    logic [7:0] st;
  } vec_t;
  vec_t v[10];

  uart_rx_fifo #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .baudrate(baudrate), .control(control), .rxd(rxd),
    .read_rx(read_rx), .rx_valid(rx_valid), .rxdata(rxdata), .status(status)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] d, bit par, bit pbit, bit stop, int bw);
    rxd = 0;
    cyc(bw);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      cyc(bw);
    end
    if (par) begin
      rxd = pbit;
      cyc(bw);
    end
    rxd = stop;
    cyc(bw);
    rxd = 1;
    cyc(bw);
  endtask

  task automatic drain(string name);
    int guard = 0;
    while (rx_valid && guard < 20) begin
      guard++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: got unexpected byte %0h expected none", name, rxdata);
      end else chk(name, rxdata, exp_q.pop_front());
      read_rx = 1;
      cyc(1);
      read_rx = 0;
    end
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_empty"}, rx_valid, 0);
    exp_q.delete();
  endtask

  task automatic clear(logic [7:0] ctrl);
    control = ctrl | 8'h30;
    cyc(1);
    control = ctrl;
  endtask

  initial begin
    v[0] = '{8'h01, 8'hA5, 0, 1, 8'h01};
    v[1] = '{8'h07, 8'h3C, 0, 1, 8'h01};
    v[2] = '{8'h07, 8'h3C, 1, 1, 8'h11};
    v[3] = '{8'h03, 8'h3C, 0, 1, 8'h01};
    v[4] = '{8'h03, 8'h01, 1, 1, 8'h11};
    v[5] = '{8'h01, 8'h00, 0, 0, 8'h48};
    v[6] = '{8'h01, 8'h55, 0, 0, 8'h08};
    v[7] = '{8'h03, 8'h00, 0, 0, 8'h48};
    v[8] = '{8'h03, 8'h00, 1, 0, 8'h18};
    v[9] = '{8'h01, 8'hFF, 0, 1, 8'h01};
    cyc(3);
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rxdata, 0);
    chk("reset_status", status, 0);
    reset = 0;
    cyc(2);
    control = 8'h01;
    cyc(2);
    fork
      send(8'hA5, 0, 0, 1, 16);
      begin
        cyc(154);
        chk("t1_before_stop", rx_valid, 0);
        cyc(1);
        chk("t1_valid", rx_valid, 1);
        chk("t1_data", rxdata, 8'hA5);
        read_rx = 1;
        cyc(1);
        read_rx = 0;
        chk("t1_popped", rx_valid, 0);
      end
    join
    foreach (v[i]) begin
      clear(v[i].ctrl);
      send(v[i].data, v[i].ctrl[1], (^v[i].data) ^ v[i].ctrl[2] ^ v[i].bad, v[i].stop, 16);
      cyc(2);
      chk($sformatf("vec%0d_status", i), status, v[i].st);
      if (v[i].stop) exp_q.push_back(v[i].data);
      drain($sformatf("vec%0d_rx", i));
    end
    clear(8'h07);
    send(8'h3C, 1, 0, 1, 16);
    cyc(2);
    chk("sticky_set", status, 8'h11);
    control = 8'h27;
    cyc(1);
    control = 8'h07;
    chk("sticky_clear", status, 8'h01);
    exp_q.push_back(8'h3C);
    drain("sticky_rx");
    clear(8'h01);
    rxd = 0;
    cyc(4);
    rxd = 1;
    chk("glitch_busy", status, 8'h20);
    cyc(20);
    chk("glitch_idle", status, 8'h00);
    clear(8'h01);
    for (int k = 1; k <= 8; k++) begin
      send(k[7:0], 0, 0, 1, 16);
      exp_q.push_back(k[7:0]);
    end
    chk("full_before", status, 8'h03);
    exp_q.push_back(8'h09);
    fork
      send(8'h09, 0, 0, 1, 16);
      begin
        cyc(154);
        chk("simul_head", rxdata, exp_q.pop_front());
        read_rx = 1;
        cyc(1);
        read_rx = 0;
        chk("simul_status", status, 8'h03);
        chk("simul_newhead", rxdata, 8'h02);
      end
    join
    drain("simul_rx");
    clear(8'h01);
    for (int k = 1; k <= 9; k++) begin
      send(k[7:0], 0, 0, 1, 16);
      if (k <= 8) exp_q.push_back(k[7:0]);
    end
    cyc(2);
    chk("overrun_status", status, 8'h07);
    drain("overrun_rx");
    clear(8'h01);
    send(8'h11, 0, 0, 1, 16);
    send(8'h22, 0, 0, 1, 16);
    chk("flush_pre", rx_valid, 1);
    control = 8'h11;
    cyc(1);
    control = 8'h01;
    chk("flush_valid", rx_valid, 0);
    chk("flush_status", status, 8'h00);
    send(8'h77, 0, 0, 1, 16);
    chk("reset_pre", rxdata, 8'h77);
    rxd = 0;
    cyc(40);
    chk("reset_mid_busy", status[5], 1);
    reset = 1;
    rxd = 1;
    cyc(1);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rxdata, 0);
    chk("rst_status", status, 0);
    cyc(2);
    reset = 0;
    cyc(20);
    chk("post_reset_empty", rx_valid, 0);
    send(8'h5A, 0, 0, 1, 16);
    exp_q.push_back(8'h5A);
    drain("post_reset_rx");
    baudrate = 16'd2;
    send(8'hC3, 0, 0, 1, 4);
    exp_q.push_back(8'hC3);
    cyc(2);
    chk("baud2_status", status, 8'h01);
    drain("baud2_rx");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
